// File: rtl/wb_init_pkg.sv
// Shared types for the Wishbone dword initiator: FSM states and
// response status codes returned on rsp_status_o.
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

endpackage

// File: rtl/wb_init_timer.sv
// Per-word timeout: loadable down-counter, expires when it reaches zero.
// Ports: clk_i, rst_n_i, i_load (restart), i_run (count), o_expired.
module wb_init_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = &{clk_i, rst_n_i, i_load, i_run};
            assign o_expired = 1'b0;
        end else begin : g_on
            logic [CW-1:0] r_cnt;

            // Loaded with TIMEOUT when stb asserts, so zero is reached
            // exactly TIMEOUT cycles later.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_cnt <= LOAD;
                end else if (i_load) begin
                    r_cnt <= LOAD;
                end else if (i_run && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_expired = (r_cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/wb_dword_initiator.sv
// Wishbone pipelined initiator: one 32/64-bit command at a time, 64-bit
// split into two words (high first) inside one cycle, one response pulse.
// Ports: clk_i/rst_n_i; cmd_* command (valid/ready); rsp_* response;
//        wb_* pipelined Wishbone master (32-bit data, word address).
module wb_dword_initiator #(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic                  cmd_wide_i,
    input  logic [ADDR_WIDTH-3:0] cmd_adr_i,
    input  logic [63:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [63:0]           rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-3:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    import wb_init_pkg::*;

    localparam int AW = ADDR_WIDTH - 2;

    state_t          r_state, w_state;
    logic            r_we, w_we;
    logic            r_wide, w_wide;
    logic [AW-1:1]   r_adr_hi, w_adr_hi;
    logic [31:0]     r_lo, w_lo;
    logic [31:0]     r_hi, w_hi;
    logic            r_word, w_word;
    logic            r_cyc, w_cyc;
    logic            r_stb, w_stb;
    logic [AW-1:0]   r_wb_adr, w_wb_adr;
    logic [31:0]     r_wb_dat, w_wb_dat;
    logic            r_rsp_valid, w_rsp_valid;
    logic [63:0]     r_rsp_dat, w_rsp_dat;
    logic [1:0]      r_status, w_status;

    logic            w_load;
    logic            w_run;
    logic            w_expired;
    logic            w_hit;
    logic            w_end;
    logic [1:0]      w_end_st;
    logic [63:0]     w_end_dat;

    assign w_run = (r_state == REQ) || (r_state == WAIT);

    // Slave responses count only in WAIT or in the REQ accept cycle.
    assign w_hit = (r_state == WAIT) ||
                   ((r_state == REQ) && !wb_stall_i);

    wb_init_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_load    (w_load),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state     = r_state;
        w_we        = r_we;
        w_wide      = r_wide;
        w_adr_hi    = r_adr_hi;
        w_lo        = r_lo;
        w_hi        = r_hi;
        w_word      = r_word;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_wb_adr    = r_wb_adr;
        w_wb_dat    = r_wb_dat;
        w_rsp_valid = 1'b0;
        w_rsp_dat   = r_rsp_dat;
        w_status    = r_status;
        w_load      = 1'b0;
        w_end       = 1'b0;
        w_end_st    = ST_OK;
        w_end_dat   = 64'h0;

        unique case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_we     = cmd_we_i;
                    w_wide   = cmd_wide_i;
                    w_adr_hi = cmd_adr_i[AW-1:1];
                    w_lo     = cmd_dat_i[31:0];
                    w_word   = 1'b0;
                    w_cyc    = 1'b1;
                    w_stb    = 1'b1;
                    w_load   = 1'b1;
                    w_state  = REQ;
                    if (cmd_wide_i) begin
                        w_wb_adr = {cmd_adr_i[AW-1:1], 1'b0};
                        w_wb_dat = cmd_dat_i[63:32];
                    end else begin
                        w_wb_adr = cmd_adr_i;
                        w_wb_dat = cmd_dat_i[31:0];
                    end
                end
            end
            REQ, WAIT: begin
                if (w_hit && (wb_err_i || wb_rty_i)) begin
                    w_end    = 1'b1;
                    w_end_st = wb_err_i ? ST_ERR : ST_RTY;
                end else if (w_hit && wb_ack_i) begin
                    if (r_wide && !r_word) begin
                        // Low word goes out right after the high word acks.
                        w_hi     = wb_dat_i;
                        w_word   = 1'b1;
                        w_stb    = 1'b1;
                        w_load   = 1'b1;
                        w_wb_adr = {r_adr_hi, 1'b1};
                        w_wb_dat = r_lo;
                        w_state  = REQ;
                    end else begin
                        w_end = 1'b1;
                        if (r_we) begin
                            w_end_dat = 64'h0;
                        end else if (r_wide) begin
                            w_end_dat = {r_hi, wb_dat_i};
                        end else begin
                            w_end_dat = {32'h0, wb_dat_i};
                        end
                    end
                end else if (w_expired) begin
                    w_end    = 1'b1;
                    w_end_st = ST_TMO;
                end else if (w_hit) begin
                    w_stb   = 1'b0;
                    w_state = WAIT;
                end
            end
            RSP: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_end) begin
            w_cyc       = 1'b0;
            w_stb       = 1'b0;
            w_rsp_valid = 1'b1;
            w_rsp_dat   = w_end_dat;
            w_status    = w_end_st;
            w_state     = RSP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_wide      <= 1'b0;
            r_adr_hi    <= '0;
            r_lo        <= 32'h0;
            r_hi        <= 32'h0;
            r_word      <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_wb_adr    <= '0;
            r_wb_dat    <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 64'h0;
            r_status    <= ST_OK;
        end else begin
            r_state     <= w_state;
            r_we        <= w_we;
            r_wide      <= w_wide;
            r_adr_hi    <= w_adr_hi;
            r_lo        <= w_lo;
            r_hi        <= w_hi;
            r_word      <= w_word;
            r_cyc       <= w_cyc;
            r_stb       <= w_stb;
            r_wb_adr    <= w_wb_adr;
            r_wb_dat    <= w_wb_dat;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
            r_status    <= w_status;
        end
    end

    assign cmd_ready_o  = (r_state == IDLE);
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_status;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_we;
    assign wb_adr_o     = r_wb_adr;
    assign wb_sel_o     = 4'hF;
    assign wb_dat_o     = r_wb_dat;

endmodule

// File: tb/tb_wb_dword_initiator.sv
// Bench for wb_dword_initiator: behavioural slave, reference model,
// expected-transfer and expected-response scoreboards.
module tb_wb_dword_initiator;

    typedef struct {
        logic [3:0]  adr;
        bit          we;
        logic [31:0] dat;
        int          widx;
    } xfer_t;

    typedef struct {
        logic [1:0]  st;
        logic [63:0] dat;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic        cmd_wide_i = 1'b0;
    logic [3:0]  cmd_adr_i = 4'h0;
    logic [63:0] cmd_dat_i = 64'h0;
    logic        rsp_valid_o;
    logic [63:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic [31:0] wb_dat_i = 32'h0;

    wb_dword_initiator #(
        .ADDR_WIDTH (6),
        .TIMEOUT    (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_wide_i   (cmd_wide_i),
        .cmd_adr_i    (cmd_adr_i),
        .cmd_dat_i    (cmd_dat_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_status_o (rsp_status_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_rty_i     (wb_rty_i),
        .wb_stall_i   (wb_stall_i),
        .wb_dat_i     (wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    xfer_t exp_x[$];
    rsp_t  exp_r[$];
    logic [31:0] model_mem [16];
    logic [31:0] slv_mem [16];

    // slave knobs: fault 0 ok,1 err,2 rty,3 silent; -1 means random
    int g_fault = 0;
    int g_fword = 0;
    int g_stall = -1;
    int g_dly = -1;
    bit force_ack = 1'b0;

    int cyc_cnt = 0;
    int acc_cyc = 0;
    int rsp_cnt = 0;
    int last_lat = 0;
    logic [63:0] last_dat = 64'h0;
    logic [1:0]  last_st = 2'b00;
    int stb_rise = 0;
    int cyc_fall = 0;
    int n_stb_rise = 0;
    int n_cyc_rise = 0;
    bit prev_stb = 1'b0;
    bit prev_cyc = 1'b0;

    int widx = 0;
    int stall_left = 0;
    int pdly = 0;
    int pkind = 0;
    bit in_req = 1'b0;
    bit pend = 1'b0;
    logic [3:0]  p_adr = 4'h0;
    bit          p_we = 1'b0;
    logic [31:0] p_dat = 32'h0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endfunction

    function automatic void fail(string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s", nm);
    endfunction

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic respond(int kind);
        case (kind)
            0: begin
                wb_ack_i = 1'b1;
                if (p_we) slv_mem[p_adr] = p_dat;
                else wb_dat_i = slv_mem[p_adr];
            end
            1: begin
                wb_err_i = 1'b1;
                wb_rty_i = $urandom_range(0, 1) == 1;
                wb_ack_i = $urandom_range(0, 1) == 1;
            end
            2: begin
                wb_rty_i = 1'b1;
                wb_ack_i = $urandom_range(0, 1) == 1;
            end
            default: ;
        endcase
    endtask

    // Slave, tracker and response monitor, all on the falling edge.
    initial forever begin
        xfer_t x;
        rsp_t  r;
        int    kind;
        int    d;
        @(negedge clk_i);

        if (wb_stb_o && !prev_stb) begin
            stb_rise = cyc_cnt;
            n_stb_rise++;
        end
        if (wb_cyc_o && !prev_cyc) n_cyc_rise++;
        if (!wb_cyc_o && prev_cyc) cyc_fall = cyc_cnt;
        prev_stb = wb_stb_o;
        prev_cyc = wb_cyc_o;

        if (rst_n_i && rsp_valid_o) begin
            rsp_cnt++;
            last_lat = cyc_cnt - acc_cyc + 1;
            last_dat = rsp_dat_o;
            last_st = rsp_status_o;
            if (exp_r.size() == 0) begin
                fail("unexpected_rsp");
            end else begin
                r = exp_r.pop_front();
                chk("rsp_status", 64'(rsp_status_o), 64'(r.st));
                chk("rsp_dat", rsp_dat_o, r.dat);
            end
            chk("rsp_cyc_low", 64'(wb_cyc_o), 64'd0);
            chk("xfers_left", 64'(exp_x.size()), 64'd0);
        end

        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i = $urandom;

        if (!rst_n_i || !wb_cyc_o) begin
            widx = 0;
            in_req = 1'b0;
            pend = 1'b0;
            if ($urandom_range(0, 3) == 0) wb_ack_i = 1'b1;
            if (force_ack) wb_ack_i = 1'b1;
        end else if (pend) begin
            if (pdly > 1) begin
                pdly--;
            end else begin
                respond(pkind);
                pend = 1'b0;
            end
        end else if (wb_stb_o) begin
            if (!in_req) begin
                in_req = 1'b1;
                stall_left = (g_stall >= 0) ? g_stall : $urandom_range(0, 2);
            end
            if (stall_left > 0) begin
                stall_left--;
                wb_stall_i = 1'b1;
                // responses while stalled must be ignored
                if ($urandom_range(0, 2) == 0) begin
                    wb_ack_i = 1'b1;
                    wb_err_i = $urandom_range(0, 1) == 1;
                    wb_rty_i = $urandom_range(0, 1) == 1;
                end
            end else begin
                if (exp_x.size() == 0) begin
                    fail("unexpected_xfer");
                end else begin
                    x = exp_x.pop_front();
                    chk("wb_adr", 64'(wb_adr_o), 64'(x.adr));
                    chk("wb_we", 64'(wb_we_o), 64'(x.we));
                    chk("word_in_cyc", 64'(widx), 64'(x.widx));
                    chk("wb_sel", 64'(wb_sel_o), 64'hF);
                    if (x.we) chk("wb_dat", 64'(wb_dat_o), 64'(x.dat));
                end
                p_adr = wb_adr_o;
                p_we = wb_we_o;
                p_dat = wb_dat_o;
                kind = (g_fault != 0 && g_fword == widx) ? g_fault : 0;
                widx++;
                in_req = 1'b0;
                d = (g_dly >= 0) ? g_dly : $urandom_range(0, 2);
                if (kind != 3) begin
                    if (d == 0) begin
                        respond(kind);
                    end else begin
                        pend = 1'b1;
                        pdly = d;
                        pkind = kind;
                    end
                end
            end
        end
    end

    // Reference model: predicts transfers and the response from the
    // command and the planned fault, then presents the command.
    task automatic start(bit we, bit wide, logic [3:0] adr,
                         logic [63:0] dat, int fault, int fword);
        rsp_t r;
        xfer_t x;
        logic [31:0] rd [2];
        int nw;
        int n;
        r.st = 2'b00;
        r.dat = 64'h0;
        rd[0] = 32'h0;
        rd[1] = 32'h0;
        nw = wide ? 2 : 1;
        for (int w = 0; w < nw; w++) begin
            x.adr = wide ? 4'(int'(adr) - int'(adr) % 2 + w) : adr;
            x.we = we;
            x.dat = (wide && w == 0) ? dat[63:32] : dat[31:0];
            x.widx = w;
            exp_x.push_back(x);
            if (fault != 0 && fword == w) begin
                r.st = (fault == 1) ? 2'b01 : (fault == 2) ? 2'b10 : 2'b11;
                break;
            end
            if (we) model_mem[x.adr] = x.dat;
            else rd[w] = model_mem[x.adr];
        end
        if (r.st == 2'b00 && !we)
            r.dat = wide ? {rd[0], rd[1]} : {32'h0, rd[0]};
        exp_r.push_back(r);
        g_fault = fault;
        g_fword = fword;
        n = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready_o), 64'd1);
        cmd_we_i = we;
        cmd_wide_i = wide;
        cmd_adr_i = adr;
        cmd_dat_i = dat;
        cmd_valid_i = 1'b1;
        acc_cyc = cyc_cnt;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i = 4'($urandom);
        cmd_dat_i = {$urandom, $urandom};
    endtask

    task automatic wait_rsp(int target);
        int n = 0;
        while (rsp_cnt < target && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (rsp_cnt < target) fail("rsp_never_came");
    endtask

    task automatic issue(bit we, bit wide, logic [3:0] adr,
                         logic [63:0] dat, int fault, int fword);
        int tgt = rsp_cnt + 1;
        start(we, wide, adr, dat, fault, fword);
        wait_rsp(tgt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int c;
        int n;
        int f;
        bit wide;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            slv_mem[i] = model_mem[i];
        end

        #3;
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_we", 64'(wb_we_o), 64'd0);
        chk("rst_adr", 64'(wb_adr_o), 64'd0);
        chk("rst_wdat", 64'(wb_dat_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_dat", rsp_dat_o, 64'd0);
        chk("rst_status", 64'(rsp_status_o), 64'd0);
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        g_stall = 0;
        g_dly = 1;
        s = n_stb_rise;
        issue(1'b1, 1'b0, 4'd3, 64'h0000_0000_CAFE_0001, 0, 0);
        chk("t1_latency", 64'(last_lat), 64'd4);
        chk("t1_one_stb", 64'(n_stb_rise - s), 64'd1);
        chk("t1_mem", 64'(slv_mem[3]), 64'hCAFE0001);

        model_mem[2] = 32'h11223344;
        slv_mem[2] = 32'h11223344;
        model_mem[3] = 32'h55667788;
        slv_mem[3] = 32'h55667788;
        c = n_cyc_rise;
        issue(1'b0, 1'b1, 4'd2, 64'h0, 0, 0);
        chk("t2_latency", 64'(last_lat), 64'd6);
        chk("t2_one_cyc", 64'(n_cyc_rise - c), 64'd1);
        chk("t2_dat", last_dat, 64'h1122334455667788);

        g_stall = 3;
        g_dly = -1;
        issue(1'b1, 1'b1, 4'd5, 64'hAAAA0000_BBBB1111, 0, 0);
        chk("t3_status", 64'(last_st), 64'd0);
        chk("t3_mem4", 64'(slv_mem[4]), 64'hAAAA0000);
        chk("t3_mem5", 64'(slv_mem[5]), 64'hBBBB1111);

        g_stall = 0;
        s = n_stb_rise;
        issue(1'b0, 1'b1, 4'd8, 64'h0, 1, 0);
        chk("t4_err_status", 64'(last_st), 64'd1);
        chk("t4_err_one_stb", 64'(n_stb_rise - s), 64'd1);
        issue(1'b0, 1'b1, 4'd10, 64'h0, 2, 0);
        chk("t4_rty_status", 64'(last_st), 64'd2);
        chk("t4_rty_dat", last_dat, 64'h0);

        g_dly = 1;
        issue(1'b0, 1'b0, 4'd9, 64'h0, 3, 0);
        chk("t5_status", 64'(last_st), 64'd3);
        chk("t5_cyc_drop", 64'(cyc_fall - stb_rise), 64'd9);
        @(negedge clk_i);
        c = rsp_cnt;
        force_ack = 1'b1;
        repeat (3) @(negedge clk_i);
        force_ack = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t5_late_ack", 64'(rsp_cnt), 64'(c));
        chk("t5_ready", 64'(cmd_ready_o), 64'd1);

        start(1'b0, 1'b1, 4'd6, 64'h0, 3, 1);
        n = 0;
        while (!(widx == 1 && wb_cyc_o && !wb_stb_o) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) fail("t6_no_wait_word1");
        c = rsp_cnt;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t6_cyc", 64'(wb_cyc_o), 64'd0);
        chk("t6_stb", 64'(wb_stb_o), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid_o), 64'd0);
        exp_r.delete();
        exp_x.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t6_ready", 64'(cmd_ready_o), 64'd1);
        chk("t6_no_rsp", 64'(rsp_cnt), 64'(c));
        issue(1'b0, 1'b0, 4'd4, 64'h0, 0, 0);
        chk("t6_after_dat", last_dat, {32'h0, model_mem[4]});

        g_stall = -1;
        g_dly = -1;
        for (int i = 0; i < 150; i++) begin
            f = $urandom_range(0, 9);
            wide = $urandom_range(0, 1) == 1;
            issue($urandom_range(0, 1) == 1, wide, 4'($urandom),
                  {$urandom, $urandom},
                  (f < 7) ? 0 : f - 6,
                  wide ? $urandom_range(0, 1) : 0);
        end
        repeat (4) @(negedge clk_i);
        chk("end_rsp_queue", 64'(exp_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
